// File: rtl/counter.sv
// N-bit up/down counter with sync clear, parallel load and a one-cycle overflow flag.
// Define COUNTER_SATURATE_EN to hold at the limits instead of wrapping modulo 2^N.
module counter #(
  parameter int N      = 20,
  parameter int LOAD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [LOAD_W-1:0] load_val,
  output logic [N-1:0]      count,
  output logic              overflow
);

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] MAX  = '1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic at_limit;

  // A step in the current direction would cross 0 (down) or 2^N-1 (up).
  assign at_limit = dir ? (count == ZERO) : (count == MAX);

  function automatic logic [N-1:0] step_val(input logic [N-1:0] c, input logic d,
                                            input logic lim);
`ifdef COUNTER_SATURATE_EN
    if (lim) return c;
`else
    if (lim) return d ? MAX : ZERO;
`endif
    return d ? (c - ONE) : (c + ONE);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= ZERO;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= ZERO;
      overflow <= 1'b0;
    end else if (load) begin
      count    <= N'(load_val);
      overflow <= 1'b0;
    end else if (en) begin
      count    <= step_val(count, dir, at_limit);
      overflow <= at_limit;
    end else begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter: a 20-bit instance (reset, wrap, priority)
// and a 4-bit instance (free run, or saturation when COUNTER_SATURATE_EN is defined).
module tb_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_clr = 1'b0, a_en = 1'b0, a_dir = 1'b0, a_load = 1'b0;
  logic [15:0] a_load_val = '0;
  logic [19:0] a_count;
  logic        a_overflow;
  logic        b_clr = 1'b0, b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0;
  logic [3:0]  b_load_val = '0;
  logic [3:0]  b_count;
  logic        b_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter #(.N(20), .LOAD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .en(a_en), .dir(a_dir), .load(a_load),
    .load_val(a_load_val), .count(a_count), .overflow(a_overflow)
  );

  counter #(.N(4), .LOAD_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .en(b_en), .dir(b_dir), .load(b_load),
    .load_val(b_load_val), .count(b_count), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int first_pulse;
    int last_pulse;

    // Reset held low across edges
    step();
    step();
    check("rst_count", 32'(a_count), 32'h0);
    check("rst_ovf", 32'(a_overflow), 32'h0);
    rst_n = 1'b1;
    a_en  = 1'b1;
    step(); check("cnt1", 32'(a_count), 32'h1);
    step(); check("cnt2", 32'(a_count), 32'h2);
    step(); check("cnt3", 32'(a_count), 32'h3);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(a_count), 32'h0);
    check("async_rst_ovf", 32'(a_overflow), 32'h0);
    step();
    check("rst_hold", 32'(a_count), 32'h0);
    rst_n = 1'b1;
    a_en  = 1'b0;

    // Load zero-extends; count up across the 16-bit boundary without overflow
    a_load = 1'b1; a_load_val = 16'hFFFF;
    step(); check("load_ffff", 32'(a_count), 32'h0FFFF);
    a_load = 1'b0; a_en = 1'b1; a_dir = 1'b0;
    step(); check("up_10000", 32'(a_count), 32'h10000);
    check("up_10000_ovf", 32'(a_overflow), 32'h0);
    a_clr = 1'b1;
    step(); check("clr", 32'(a_count), 32'h0);
    a_clr = 1'b0; a_dir = 1'b1;

`ifndef COUNTER_SATURATE_EN
    // Wrap down then wrap up
    step(); check("wrapdn_count", 32'(a_count), 32'hFFFFF);
    check("wrapdn_ovf", 32'(a_overflow), 32'h1);
    step(); check("dn_fffe", 32'(a_count), 32'hFFFFE);
    check("dn_fffe_ovf", 32'(a_overflow), 32'h0);
    a_dir = 1'b0;
    step(); check("up_fffff", 32'(a_count), 32'hFFFFF);
    check("up_fffff_ovf", 32'(a_overflow), 32'h0);
    step(); check("wrapup_count", 32'(a_count), 32'h0);
    check("wrapup_ovf", 32'(a_overflow), 32'h1);
    step(); check("after_wrap", 32'(a_count), 32'h1);
    check("after_wrap_ovf", 32'(a_overflow), 32'h0);
`else
    // Held against zero while counting down
    step(); check("satdn_count", 32'(a_count), 32'h0);
    check("satdn_ovf", 32'(a_overflow), 32'h1);
    step(); check("satdn_count2", 32'(a_count), 32'h0);
    check("satdn_ovf2", 32'(a_overflow), 32'h1);
    a_dir = 1'b0;
    step(); check("satdn_release", 32'(a_count), 32'h1);
    check("satdn_release_ovf", 32'(a_overflow), 32'h0);
`endif

    // Priority: clr > load > en > hold
    a_en = 1'b0; a_load = 1'b1; a_load_val = 16'h0005;
    step(); check("load5", 32'(a_count), 32'h5);
    a_clr = 1'b1; a_en = 1'b1;
    step(); check("prio_clr", 32'(a_count), 32'h0);
    check("prio_clr_ovf", 32'(a_overflow), 32'h0);
    a_clr = 1'b0; a_en = 1'b0; a_load_val = 16'h0005;
    step(); check("reload5", 32'(a_count), 32'h5);
    a_en = 1'b1; a_load_val = 16'h1234;
    step(); check("prio_load", 32'(a_count), 32'h01234);
    a_load = 1'b0; a_en = 1'b0;
    step(); check("hold", 32'(a_count), 32'h01234);
    check("hold_ovf", 32'(a_overflow), 32'h0);

`ifndef COUNTER_SATURATE_EN
    // Free run on the 4-bit instance: period 16, overflow pulses when count==0
    b_en = 1'b1; b_dir = 1'b0;
    pulses = 0; first_pulse = -1; last_pulse = -1;
    for (int k = 1; k <= 32; k++) begin
      step();
      check("free_count", 32'(b_count), 32'(k % 16));
      check("free_ovf", 32'(b_overflow), ((k % 16) == 0) ? 32'h1 : 32'h0);
      if (b_overflow) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
        last_pulse = k;
      end
    end
    check("free_pulses", 32'(pulses), 32'd2);
    check("free_spacing", 32'(last_pulse - first_pulse), 32'd16);
`else
    // Saturate at 15 on the 4-bit instance
    b_load = 1'b1; b_load_val = 4'hF;
    step(); check("sat_load", 32'(b_count), 32'hF);
    b_load = 1'b0; b_en = 1'b1; b_dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("sat_count", 32'(b_count), 32'hF);
      check("sat_ovf", 32'(b_overflow), 32'h1);
    end
    b_dir = 1'b1;
    step(); check("sat_down", 32'(b_count), 32'hE);
    check("sat_down_ovf", 32'(b_overflow), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
